pwm_modulo: RTL and testbench
=============================

Name: pwm_modulo

Overview:
- Downstream consumer of `counter_modulo`. Takes the running counter value `cnt` and the period-wrap strobe `wrp`, and produces a complementary PWM pair (`out_h`/`out_l`) with programmable dead time.
- Duty and dead-time settings arrive over a valid/ready config port. They are double-buffered and applied only at a period boundary, so no glitched or truncated period is ever emitted.

Parameters:
- WIDTH, 32, width of the counter value; matches the upstream counter WIDTH.
- DTW, 8, width of the dead-time setting in clock cycles.

Ports:
- clk      input   1        clock
- rst      input   1        asynchronous reset, active-high
- ena      input   1        counter enable, the same signal that drives the upstream counter
- cnt      input   WIDTH    upstream counter value
- wrp      input   1        upstream wrap status (cnt == mod-1)
- cfg_vld  input   1        config valid
- cfg_rdy  output  1        config ready
- cfg_dty  input   WIDTH+1  duty: number of counter states per period with the high side requested
- cfg_dtm  input   DTW      dead time in clk cycles
- out_h    output  1        high-side drive
- out_l    output  1        low-side drive
- upd      output  1        one-cycle pulse: new config applied

Behaviour:
- Reset values (asynchronous, while rst=1):
  - out_h=0, out_l=0, upd=0, cfg_rdy=1.
  - Pending and active registers are cleared to dty=0, dtm=0.
  - Pending flag pnd=0.
  - raw_q=0, FSM in state DEAD_L, dead counter dc=0.
- Config handshake:
  - cfg_rdy = !pnd.
  - A transfer occurs when cfg_vld & cfg_rdy. The transfer loads the pending register and sets pnd.
  - cfg_vld may be held while cfg_rdy=0; nothing is captured until cfg_rdy=1.
- Period boundary: `bnd = ena & wrp`.
  - On bnd with pnd=1, the pending register copies into active and pnd clears. upd=1 on the next cycle; cfg_rdy returns to 1 on the next cycle.
  - On bnd with pnd=0, active is unchanged and upd=0.
  - If a transfer and bnd occur in the same cycle (possible only when pnd=0), the transferred value goes to pending only. It is applied at the following boundary.
- Compare stage:
  - Registered every clk: `raw_q <= ({1'b0,cnt} < act_dty)`.
  - Latency is 1 cycle from cnt to raw_q.
  - act_dty=0 gives raw_q constantly 0.
  - act_dty >= modulo gives raw_q constantly 1 (100% duty).
  - The compare uses the active value, so a new duty takes effect from cnt=0 of the new period.
- Dead-time FSM (one-hot or encoded; states LOW_ON, DEAD_H, HIGH_ON, DEAD_L):
  - LOW_ON: out_l=1, out_h=0. If raw_q=1: go to HIGH_ON when act_dtm=0, otherwise go to DEAD_H with dc<=act_dtm-1.
  - DEAD_H: both outputs 0. If raw_q=0: go to LOW_ON (abort). Else if dc=0: go to HIGH_ON. Else dc<=dc-1.
  - HIGH_ON: out_h=1, out_l=0. If raw_q=0: go to DEAD_L with dc<=act_dtm-1 (or straight to LOW_ON when act_dtm=0).
  - DEAD_L: both outputs 0. If raw_q=1: go to HIGH_ON when act_dtm=0, otherwise go to DEAD_H with dc<=act_dtm-1. Else if dc=0: go to LOW_ON. Else dc<=dc-1.
  - The dead interval is exactly act_dtm cycles with both outputs low.
  - dc counts clk cycles, independent of ena.
  - Outputs are registered, decoded from the state register.
- Invariant: out_h & out_l is never 1, including across reset and config changes.
- After reset release: DEAD_L with dc=0 and raw_q=0, so LOW_ON is entered on the first clk edge and out_l=1 from cycle 1.
- Mid-operation reset: all outputs drop asynchronously and the pending config is discarded.
- act_dtm changes take effect at the next dead interval start; an interval already in progress completes with its loaded dc.

Test Plan:
- Reset, counter mod=10, ena=1, no config -> out_h stays 0; out_l=1 from first cycle after release; cfg_rdy=1.
- cfg dty=4, dtm=0 accepted mid-period -> cfg_rdy=0 until boundary; upd pulses the cycle after wrp; thereafter out_h high for 4 of every 10 cycles, out_l high for 6, outputs lagging cnt by 2 cycles.
- dty=5, dtm=2 -> per period: out_h high 3 cycles, out_l high 3 cycles, two 2-cycle gaps with both low; out_h&out_l never 1.
- dty=1, dtm=3 (high request shorter than dead time) -> DEAD_H aborts to LOW_ON; out_h never asserts; out_l low for at most 1 cycle per period.
- dty=10 and dty=0 with mod=10 -> constant out_h=1 (after the dead interval) / constant out_l=1; no upd without a new transfer.
- Transfer asserted in the same cycle as ena&wrp -> value applied at the next wrap, not the current one. Assert rst mid-HIGH_ON -> out_h=0 immediately; cfg_rdy=1.

Source files
------------

// File: rtl/pwm_modulo.sv
// ============================================================================
// Module   : pwm_modulo
// Brief    : Complementary PWM pair with dead time, driven by an upstream
//            modulo counter; config is double-buffered to period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_modulo #(
   parameter int WIDTH = 32,
   parameter int DTW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] cnt,
   input  logic             wrp,
   input  logic             cfg_vld,
   output logic             cfg_rdy,
   input  logic [WIDTH:0]   cfg_dty,
   input  logic [DTW-1:0]   cfg_dtm,
   output logic             out_h,
   output logic             out_l,
   output logic             upd
);

   localparam logic [DTW-1:0] C_DTM_ONE  = DTW'(1);
   localparam logic [DTW-1:0] C_DTM_ZERO = '0;

   typedef enum logic [1:0] {
      LOW_ON  = 2'd0,
      DEAD_H  = 2'd1,
      HIGH_ON = 2'd2,
      DEAD_L  = 2'd3
   } state_t;

   logic             r_pnd;
   logic [WIDTH:0]   r_pnd_dty;
   logic [DTW-1:0]   r_pnd_dtm;
   logic [WIDTH:0]   r_act_dty;
   logic [DTW-1:0]   r_act_dtm;
   logic             r_upd;
   logic             r_raw;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [DTW-1:0]   r_dc;
   logic [DTW-1:0]   w_dc_nxt;
   logic [DTW-1:0]   w_dtm_m1;
   logic             r_out_h;
   logic             r_out_l;
   logic             w_bnd;
   logic             w_xfer;

   assign w_bnd    = ena & wrp;
   assign w_xfer   = cfg_vld & ~r_pnd;
   assign cfg_rdy  = ~r_pnd;
   assign upd      = r_upd;
   assign out_h    = r_out_h;
   assign out_l    = r_out_l;
   assign w_dtm_m1 = r_act_dtm - C_DTM_ONE;

   // A transfer needs pnd=0 and an apply needs pnd=1, so the two never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pnd     <= 1'b0;
         r_pnd_dty <= '0;
         r_pnd_dtm <= '0;
         r_act_dty <= '0;
         r_act_dtm <= '0;
         r_upd     <= 1'b0;
      end else begin
         r_upd <= w_bnd & r_pnd;
         r_pnd <= w_xfer | (r_pnd & ~w_bnd);
         if (w_bnd && r_pnd) begin
            r_act_dty <= r_pnd_dty;
            r_act_dtm <= r_pnd_dtm;
         end
         if (w_xfer) begin
            r_pnd_dty <= cfg_dty;
            r_pnd_dtm <= cfg_dtm;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_raw <= 1'b0;
      end else begin
         r_raw <= ({1'b0, cnt} < r_act_dty);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= DEAD_L;
         r_dc    <= '0;
         r_out_h <= 1'b0;
         r_out_l <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dc    <= w_dc_nxt;
         r_out_h <= (w_state_nxt == HIGH_ON);
         r_out_l <= (w_state_nxt == LOW_ON);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dc_nxt    = r_dc;
      case (r_state)
         LOW_ON: begin
            if (r_raw) begin
               if (r_act_dtm == C_DTM_ZERO) begin
                  w_state_nxt = HIGH_ON;
               end else begin
                  w_state_nxt = DEAD_H;
                  w_dc_nxt    = w_dtm_m1;
               end
            end
         end
         DEAD_H: begin
            // A high request shorter than the dead time falls back to low side.
            if (!r_raw) begin
               w_state_nxt = LOW_ON;
            end else if (r_dc == C_DTM_ZERO) begin
               w_state_nxt = HIGH_ON;
            end else begin
               w_dc_nxt = r_dc - C_DTM_ONE;
            end
         end
         HIGH_ON: begin
            if (!r_raw) begin
               if (r_act_dtm == C_DTM_ZERO) begin
                  w_state_nxt = LOW_ON;
               end else begin
                  w_state_nxt = DEAD_L;
                  w_dc_nxt    = w_dtm_m1;
               end
            end
         end
         DEAD_L: begin
            if (r_raw) begin
               if (r_act_dtm == C_DTM_ZERO) begin
                  w_state_nxt = HIGH_ON;
               end else begin
                  w_state_nxt = DEAD_H;
                  w_dc_nxt    = w_dtm_m1;
               end
            end else if (r_dc == C_DTM_ZERO) begin
               w_state_nxt = LOW_ON;
            end else begin
               w_dc_nxt = r_dc - C_DTM_ONE;
            end
         end
         default: begin
            w_state_nxt = DEAD_L;
            w_dc_nxt    = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_pwm_modulo.sv
// ============================================================================
// Module   : tb_pwm_modulo
// Brief    : Self-checking bench for pwm_modulo with a modulo-10 counter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_modulo;

   localparam int WIDTH = 32;
   localparam int DTW   = 8;
   localparam int MOD   = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic [WIDTH-1:0] cnt;
   logic             wrp;
   logic             cfg_vld;
   logic             cfg_rdy;
   logic [WIDTH:0]   cfg_dty;
   logic [DTW-1:0]   cfg_dtm;
   logic             out_h;
   logic             out_l;
   logic             upd;

   always #5 clk = ~clk;

   pwm_modulo #(.WIDTH(WIDTH), .DTW(DTW)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .cnt     (cnt),
      .wrp     (wrp),
      .cfg_vld (cfg_vld),
      .cfg_rdy (cfg_rdy),
      .cfg_dty (cfg_dty),
      .cfg_dtm (cfg_dtm),
      .out_h   (out_h),
      .out_l   (out_l),
      .upd     (upd)
   );

   typedef struct { logic chk; logic h; logic l; } exp_t;
   typedef struct { int dty; int dtm; int nh; int nl; } vec_t;

   exp_t sb[$];
   vec_t tbl[6];
   int   n_cmp = 0;
   int   n_err = 0;
   int   m_act_d, m_act_t, m_pnd_d, m_pnd_t;
   bit   m_pnd, m_upd, m_skip;
   int   cnt_h, cnt_l;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Steady-state output for lagged counter phase q under duty d, dead time t.
   function automatic exp_t model(input int q, input int d, input int t);
      exp_t e;
      e.chk = 1'b1; e.h = 1'b0; e.l = 1'b0;
      if (d == 0) begin
         e.l = 1'b1;
      end else if (d >= MOD) begin
         e.h   = 1'b1;
         e.chk = (q >= t);
      end else if (d <= t) begin
         e.l = (q >= d);
      end else begin
         e.h = (q >= t) && (q < d);
         e.l = (q >= d + t);
      end
      return e;
   endfunction

   task automatic model_reset();
      m_act_d = 0; m_act_t = 0; m_pnd_d = 0; m_pnd_t = 0;
      m_pnd = 0; m_upd = 0; m_skip = 0;
      sb.delete();
   endtask

   task automatic tick();
      logic bnd, xfer;
      exp_t e, p;
      bnd  = ena && wrp;
      xfer = cfg_vld && !m_pnd;
      e = model(int'(cnt), m_act_d, m_act_t);
      if (m_skip) e.chk = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      m_upd = bnd && m_pnd;
      if (m_upd) begin
         m_skip  = (m_act_d >= MOD) && (m_pnd_d < MOD);
         m_act_d = m_pnd_d;
         m_act_t = m_pnd_t;
         m_pnd   = 0;
      end else if (bnd) begin
         m_skip = 0;
      end
      if (xfer) begin
         m_pnd_d = int'(cfg_dty);
         m_pnd_t = int'(cfg_dtm);
         m_pnd   = 1;
      end
      check("upd", upd, m_upd);
      check("cfg_rdy", cfg_rdy, !m_pnd);
      check("excl", out_h & out_l, 0);
      if (sb.size() == 2) begin
         p = sb.pop_front();
         if (p.chk) begin
            check("out_h", out_h, p.h);
            check("out_l", out_l, p.l);
         end
      end
      cnt_h += int'(out_h);
      cnt_l += int'(out_l);
      if (ena) cnt = wrp ? '0 : cnt + 32'd1;
      wrp = (cnt == WIDTH'(MOD - 1));
   endtask

   task automatic wait_cnt(input int v);
      int k = 0;
      while (cnt != WIDTH'(v) && k < 3 * MOD) begin tick(); k++; end
      check("wait_cnt", cnt, WIDTH'(v));
   endtask

   task automatic wait_upd();
      int k = 0;
      while (upd !== 1'b1 && k < 4 * MOD) begin tick(); k++; end
      check("upd_wait", upd, 1);
   endtask

   task automatic send(input int d, input int t);
      cfg_vld = 1'b1;
      cfg_dty = (WIDTH+1)'(d);
      cfg_dtm = DTW'(t);
      tick();
      cfg_vld = 1'b0;
   endtask

   task automatic measure(input string name, input int nh, input int nl);
      cnt_h = 0; cnt_l = 0;
      repeat (MOD) tick();
      check({name, "_nh"}, cnt_h, nh);
      check({name, "_nl"}, cnt_l, nl);
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; cnt = '0; wrp = 1'b0;
      cfg_vld = 1'b0; cfg_dty = '0; cfg_dtm = '0;
      model_reset();
   endtask

   initial begin
      tbl[0] = '{4, 0, 4, 6};
      tbl[1] = '{5, 2, 3, 3};
      tbl[2] = '{1, 3, 0, 9};
      tbl[3] = '{10, 2, 10, 0};
      tbl[4] = '{0, 2, 0, 10};
      tbl[5] = '{7, 1, 6, 2};

      do_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_h", out_h, 0);
      check("rst_out_l", out_l, 0);
      check("rst_upd", upd, 0);
      check("rst_cfg_rdy", cfg_rdy, 1);
      @(negedge clk);
      rst = 1'b0; ena = 1'b1;
      tick();
      check("first_out_l", out_l, 1);
      repeat (2 * MOD) tick();

      for (int i = 0; i < 6; i++) begin
         wait_cnt(3);
         send(tbl[i].dty, tbl[i].dtm);
         check("pending_rdy", cfg_rdy, 0);
         wait_upd();
         repeat (MOD) tick();
         measure($sformatf("row%0d", i), tbl[i].nh, tbl[i].nl);
      end

      // Transfer coincident with the boundary, a held request while busy,
      // and a stalled counter sitting on wrp.
      wait_cnt(9);
      send(3, 1);
      check("same_cyc_no_upd", upd, 0);
      check("same_cyc_rdy", cfg_rdy, 0);
      cfg_vld = 1'b1; cfg_dty = (WIDTH+1)'(6); cfg_dtm = DTW'(0);
      wait_cnt(9);
      ena = 1'b0;
      repeat (3) tick();
      ena = 1'b1;
      wait_upd();
      tick();
      cfg_vld = 1'b0;
      check("held_captured", cfg_rdy, 0);
      wait_upd();
      repeat (MOD) tick();
      measure("held", 6, 4);

      // Reset in the middle of HIGH_ON with a config pending.
      wait_cnt(3);
      send(10, 0);
      wait_upd();
      repeat (MOD + 3) tick();
      check("high_before_rst", out_h, 1);
      send(4, 0);
      #2;
      do_reset();
      #1;
      check("async_out_h", out_h, 0);
      check("async_out_l", out_l, 0);
      check("async_rdy", cfg_rdy, 1);
      @(negedge clk);
      rst = 1'b0; ena = 1'b1;
      tick();
      check("rerun_out_l", out_l, 1);
      repeat (3 * MOD) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
